// File: rtl/fetch_controller_if.sv
// Memory request/response bundle between the fetch
// controller (master) and the word-wide memory model (slave).
interface fetch_controller_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
);
    logic [ADDRESS_WIDTH-1:0] o_mem_address;
    logic                     o_mem_valid;
    logic                     i_mem_ready;
    logic                     i_mem_res_valid;
    logic [DATA_WIDTH-1:0]    i_mem_data;

    modport master (
        output o_mem_address,
        output o_mem_valid,
        input  i_mem_ready,
        input  i_mem_res_valid,
        input  i_mem_data
    );

    modport slave (
        input  o_mem_address,
        input  o_mem_valid,
        output i_mem_ready,
        output i_mem_res_valid,
        output i_mem_data
    );
endinterface

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: aligned word reads into a byte
// queue, presented to the decoder as a 4-byte window.
module fetch_controller #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int QUEUE_BYTES   = 16,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    fetch_controller_if.master       mem,
    output logic [31:0]              o_window,
    output logic [2:0]               o_window_bytes,
    output logic [ADDRESS_WIDTH-1:0] o_window_pc,
    input  logic [2:0]               i_consume,
    input  logic                     i_redirect,
    input  logic [ADDRESS_WIDTH-1:0] i_redirect_pc,
    output logic                     o_underflow
);
    localparam int PW = $clog2(QUEUE_BYTES);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DISCARD
    } state_t;

    state_t                   state;
    state_t                   state_n;
    logic [ADDRESS_WIDTH-1:0] fetch_addr;
    logic [ADDRESS_WIDTH-1:0] window_pc;
    logic [1:0]               skip;
    logic [7:0]               queue [QUEUE_BYTES];
    logic [PW-1:0]            head;
    logic [PW-1:0]            tail;
    logic [CW-1:0]            count;
    logic                     underflow;

    logic [DATA_WIDTH-1:0]    rdata;
    logic                     handshake;
    logic                     response;
    logic                     accept;
    logic                     fits;
    logic                     over;
    logic [2:0]               win_bytes;
    logic [2:0]               consume_eff;
    logic [2:0]               wr_bytes;

    assign rdata     = mem.i_mem_data;
    assign handshake = (state == S_REQ) && mem.i_mem_ready;
    assign response  = mem.i_mem_res_valid;
    assign accept    = (state == S_WAIT) && response && !i_redirect;
    assign fits      = count <= CW'(QUEUE_BYTES - 4);
    assign wr_bytes  = 3'd4 - {1'b0, skip};

    assign win_bytes   = (count >= CW'(4)) ? 3'd4 : count[2:0];
    assign over        = i_consume > win_bytes;
    assign consume_eff = over ? win_bytes : i_consume;

    assign o_window_bytes = win_bytes;
    assign o_window_pc    = window_pc;
    assign o_underflow    = underflow;

    // Window: up to four head bytes, invalid lanes forced to zero.
    always_comb begin
        o_window = '0;
        for (int i = 0; i < 4; i++) begin
            if (CW'(i) < count)
                o_window[8*i +: 8] = queue[head + PW'(i)];
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset)
            state <= S_IDLE;
        else
            state <= state_n;
    end

    // Next state; a redirect with a response in flight must drop it.
    always_comb begin
        state_n = state;
        if (i_redirect) begin
            unique case (state)
                S_REQ:
                    state_n = handshake ? S_DISCARD : S_IDLE;
                S_WAIT, S_DISCARD:
                    state_n = response ? S_IDLE : S_DISCARD;
                default:
                    state_n = S_IDLE;
            endcase
        end else begin
            unique case (state)
                S_IDLE:
                    if (fits) state_n = S_REQ;
                S_REQ:
                    if (mem.i_mem_ready) state_n = S_WAIT;
                S_WAIT, S_DISCARD:
                    if (response) state_n = S_IDLE;
                default:
                    state_n = S_IDLE;
            endcase
        end
    end

    // Request outputs are a pure function of state and fetch address.
    always_comb begin
        mem.o_mem_valid   = (state == S_REQ);
        mem.o_mem_address = fetch_addr;
    end

    // Pointers, occupancy, fetch/window addresses and underflow flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            fetch_addr <= {RESET_PC[ADDRESS_WIDTH-1:2], 2'b00};
            skip       <= RESET_PC[1:0];
            window_pc  <= RESET_PC;
            underflow  <= 1'b0;
        end else if (i_redirect) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            fetch_addr <= {i_redirect_pc[ADDRESS_WIDTH-1:2], 2'b00};
            skip       <= i_redirect_pc[1:0];
            window_pc  <= i_redirect_pc;
            underflow  <= 1'b0;
        end else begin
            head      <= head + PW'(consume_eff);
            window_pc <= window_pc + ADDRESS_WIDTH'(consume_eff);
            underflow <= over;
            if (accept) begin
                tail       <= tail + PW'(wr_bytes);
                count      <= count - CW'(consume_eff) + CW'(wr_bytes);
                fetch_addr <= fetch_addr + ADDRESS_WIDTH'(4);
                skip       <= 2'd0;
            end else begin
                count <= count - CW'(consume_eff);
            end
        end
    end

    // Byte storage: lanes below the skip count are not written.
    always_ff @(posedge clk) begin
        if (reset && accept) begin
            for (int i = 0; i < 4; i++) begin
                if (i >= int'(skip))
                    queue[tail + PW'(i) - PW'(skip)] <= rdata[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: memory responder plus a byte-level
// model of the queue contents, checked every cycle.
module tb_fetch_controller;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] o_window;
    logic [2:0]  o_window_bytes;
    logic [31:0] o_window_pc;
    logic [2:0]  i_consume;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        o_underflow;

    always #5 clk = ~clk;

    fetch_controller_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) mem ();

    fetch_controller dut (
        .clk           (clk),
        .reset         (reset),
        .mem           (mem),
        .o_window      (o_window),
        .o_window_bytes(o_window_bytes),
        .o_window_pc   (o_window_pc),
        .i_consume     (i_consume),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_underflow   (o_underflow)
    );

    int vectors = 0;
    int miscompares = 0;

    // model: queue holds bytes m_pc .. m_pc+m_count-1
    logic [31:0] m_pc;
    logic [31:0] m_fetch;
    int          m_count;
    bit          m_out;
    bit          m_stale;
    bit          m_uf;

    // memory responder
    bit          pend;
    int          lat_left;
    logic [31:0] pend_addr;
    int          lat = 1;
    bit          rdy_rand = 0;
    bit          rdy_fix = 1;
    int          hs_count;
    logic [31:0] last_hs_addr;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] byte_at(input logic [31:0] a);
        return 8'((a + 32'd1) * 32'd17);
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {byte_at(a + 3), byte_at(a + 2), byte_at(a + 1), byte_at(a)};
    endfunction

    task automatic compare();
        int nb;
        logic [31:0] w;
        nb = (m_count > 4) ? 4 : m_count;
        w = '0;
        for (int i = 0; i < nb; i++)
            w[8*i +: 8] = byte_at(m_pc + 32'(i));
        chk("window", o_window, w);
        chk("window_bytes", 32'(o_window_bytes), 32'(nb));
        chk("window_pc", o_window_pc, m_pc);
        chk("underflow", 32'(o_underflow), 32'(m_uf));
        if (mem.o_mem_valid)
            chk("req_address", mem.o_mem_address, m_fetch);
    endtask

    task automatic drive_mem();
        mem.i_mem_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fix;
        if (pend && lat_left <= 1) begin
            mem.i_mem_res_valid = 1'b1;
            mem.i_mem_data = word_at(pend_addr);
        end else begin
            mem.i_mem_res_valid = 1'b0;
            mem.i_mem_data = '0;
            if (pend) lat_left--;
        end
    endtask

    task automatic cycle(input logic [2:0] cons, input bit redir,
                         input logic [31:0] rpc);
        bit hs;
        bit res;
        logic [31:0] hs_addr;
        int wb;
        int c;
        int w;
        i_consume = cons;
        i_redirect = redir;
        i_redirect_pc = rpc;
        #1;
        hs = mem.o_mem_valid && mem.i_mem_ready;
        hs_addr = mem.o_mem_address;
        res = mem.i_mem_res_valid;
        if (hs) begin
            hs_count++;
            last_hs_addr = hs_addr;
            chk("one_outstanding", 32'(m_out), 32'd0);
            chk("req_fits", 32'(m_count + 4 <= 16), 32'd1);
        end
        @(posedge clk);
        #1;
        m_uf = 1'b0;
        if (redir) begin
            m_pc = rpc;
            m_count = 0;
            m_fetch = {rpc[31:2], 2'b00};
            if (res) begin
                m_out = 0;
                m_stale = 0;
            end else if (hs || m_out) begin
                m_out = 1;
                m_stale = 1;
            end
        end else begin
            wb = (m_count > 4) ? 4 : m_count;
            c = (int'(cons) > wb) ? wb : int'(cons);
            m_uf = int'(cons) > wb;
            w = 0;
            if (res) begin
                if (!m_stale) begin
                    chk("resp_addr", pend_addr, m_fetch);
                    w = int'(m_fetch + 32'd4 - (m_pc + 32'(m_count)));
                    m_fetch = m_fetch + 32'd4;
                end
                m_out = 0;
                m_stale = 0;
            end
            m_pc = m_pc + 32'(c);
            m_count = m_count - c + w;
            if (hs) begin
                m_out = 1;
                m_stale = 0;
            end
        end
        if (res) pend = 0;
        if (hs) begin
            pend = 1;
            pend_addr = hs_addr;
            lat_left = lat;
        end
        compare();
        drive_mem();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        i_consume = '0;
        i_redirect = 1'b0;
        i_redirect_pc = '0;
        mem.i_mem_ready = rdy_fix;
        mem.i_mem_res_valid = 1'b0;
        mem.i_mem_data = '0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        m_pc = '0;
        m_count = 0;
        m_fetch = '0;
        m_out = 0;
        m_stale = 0;
        m_uf = 0;
        pend = 0;
        hs_count = 0;
        chk("rst_mem_valid", 32'(mem.o_mem_valid), 32'd0);
        chk("rst_mem_address", mem.o_mem_address, 32'd0);
        compare();
        drive_mem();
    endtask

    task automatic run_until_bytes(input int n, input int budget);
        for (int k = 0; k < budget && int'(o_window_bytes) < n; k++)
            cycle(3'd0, 1'b0, 32'd0);
        chk("wait_window_bytes", 32'(int'(o_window_bytes) >= n), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        i_consume = '0;
        i_redirect = 1'b0;
        i_redirect_pc = '0;
        mem.i_mem_ready = 1'b0;
        mem.i_mem_res_valid = 1'b0;
        mem.i_mem_data = '0;
        @(posedge clk);
        #1;

        // first fetch and window after the first word
        do_reset();
        cycle(3'd0, 1'b0, 32'd0);
        chk("first_req_valid", 32'(mem.o_mem_valid), 32'd1);
        chk("first_req_addr", mem.o_mem_address, 32'd0);
        run_until_bytes(4, 20);
        chk("w0_window", o_window, 32'h4433_2211);
        chk("w0_bytes", 32'(o_window_bytes), 32'd4);
        chk("w0_pc", o_window_pc, 32'd0);

        // fill to 16 bytes, then throttle on free space
        repeat (40) cycle(3'd0, 1'b0, 32'd0);
        chk("fill_requests", 32'(hs_count), 32'd4);
        chk("fill_valid_low", 32'(mem.o_mem_valid), 32'd0);
        cycle(3'd1, 1'b0, 32'd0);
        repeat (10) cycle(3'd0, 1'b0, 32'd0);
        chk("one_free_requests", 32'(hs_count), 32'd4);
        chk("one_free_pc", o_window_pc, 32'd1);
        chk("one_free_window", o_window, 32'h5544_3322);
        cycle(3'd3, 1'b0, 32'd0);
        repeat (10) cycle(3'd0, 1'b0, 32'd0);
        chk("refill_requests", 32'(hs_count), 32'd5);
        chk("refill_addr", last_hs_addr, 32'h10);
        chk("refill_window", o_window, 32'h8877_6655);

        // consume three once the window is full
        do_reset();
        run_until_bytes(4, 20);
        cycle(3'd3, 1'b0, 32'd0);
        repeat (10) cycle(3'd0, 1'b0, 32'd0);
        chk("c3_pc", o_window_pc, 32'd3);
        chk("c3_window", o_window, 32'h7766_5544);

        // redirect to 6 while the first read is outstanding
        lat = 5;
        do_reset();
        cycle(3'd0, 1'b0, 32'd0);
        cycle(3'd0, 1'b0, 32'd0);
        chk("redir_outstanding", 32'(hs_count), 32'd1);
        cycle(3'd0, 1'b1, 32'h6);
        run_until_bytes(1, 40);
        chk("redir_requests", 32'(hs_count), 32'd2);
        chk("redir_req_addr", last_hs_addr, 32'h4);
        chk("redir_window", o_window, 32'h0000_8877);
        chk("redir_bytes", 32'(o_window_bytes), 32'd2);
        chk("redir_pc", o_window_pc, 32'd6);

        // over-consume: clamp and one-cycle underflow pulse
        cycle(3'd4, 1'b0, 32'd0);
        chk("uf_pulse", 32'(o_underflow), 32'd1);
        chk("uf_pc", o_window_pc, 32'd8);
        chk("uf_bytes", 32'(o_window_bytes), 32'd0);
        cycle(3'd0, 1'b0, 32'd0);
        chk("uf_clear", 32'(o_underflow), 32'd0);

        // reset while a request is being held
        rdy_fix = 0;
        for (int k = 0; k < 40 && !mem.o_mem_valid; k++)
            cycle(3'd0, 1'b0, 32'd0);
        chk("held_req_valid", 32'(mem.o_mem_valid), 32'd1);
        do_reset();
        rdy_fix = 1;
        cycle(3'd0, 1'b0, 32'd0);
        chk("restart_valid", 32'(mem.o_mem_valid), 32'd1);
        chk("restart_addr", mem.o_mem_address, 32'd0);
        lat = 1;
        run_until_bytes(4, 30);
        chk("restart_window", o_window, 32'h4433_2211);

        // mixed traffic against the model
        rdy_rand = 1;
        for (int k = 0; k < 1500; k++) begin
            logic [2:0] cons;
            bit redir;
            if (!pend) lat = $urandom_range(1, 4);
            cons = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(5, 7))
                                                : 3'($urandom_range(0, 4));
            redir = ($urandom_range(0, 39) == 0);
            cycle(cons, redir, 32'($urandom_range(0, 255)));
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fetch_controller.md
Name: fetch_controller

Overview:
- Sequences instruction fetch from the word-wide memory model and feeds the x86 decoder a byte stream.
- Issues aligned 32-bit reads over the memory request/response handshake and buffers returned bytes in a prefetch byte queue.
- Presents a 4-byte little-endian window plus a valid-byte count to the decoder, and retires however many bytes the decoder consumes each cycle.
- Supports a redirect (branch/restart) that flushes the queue and restarts fetch at any byte address.

Parameters:
- ADDRESS_WIDTH, 32, width of the memory byte address.
- DATA_WIDTH, 32, memory word width. Fixed at 32; other values are unsupported.
- QUEUE_BYTES, 16, prefetch queue depth in bytes. Power of two, at least 8.
- RESET_PC, 0, byte address fetched after reset.

Ports:
- clk, input, 1, clock. All state changes on the rising edge.
- reset, input, 1, synchronous, active-low reset.
- o_mem_address, output, ADDRESS_WIDTH, word-aligned read address (bits [1:0] always 0).
- o_mem_valid, output, 1, read request.
- i_mem_ready, input, 1, memory can accept a request.
- i_mem_res_valid, input, 1, read data valid this cycle.
- i_mem_data, input, DATA_WIDTH, read data; byte 0 in bits [7:0].
- o_window, output, 32, next 4 queued bytes; head byte in [7:0]; invalid bytes read as 0.
- o_window_bytes, output, 3, number of valid bytes in o_window, 0..4.
- o_window_pc, output, ADDRESS_WIDTH, byte address of the head byte.
- i_consume, input, 3, bytes retired by the decoder this cycle, 0..4.
- i_redirect, input, 1, flush and restart fetch.
- i_redirect_pc, input, ADDRESS_WIDTH, new byte address; any alignment.
- o_underflow, output, 1, one-cycle pulse when i_consume > o_window_bytes.

Behaviour:
- Reset (reset==0 at a clock edge):
  - queue emptied; o_mem_valid=0; o_mem_address = RESET_PC with bits [1:0] cleared.
  - o_window_pc=RESET_PC; skip count = RESET_PC[1:0]; o_window_bytes=0; o_window=0; o_underflow=0; FSM enters IDLE.
  - Reset mid-request abandons the request; no response is awaited.
- FSM states:
  - IDLE: if free bytes ≥ 4, go to REQ and assert o_mem_valid on the next cycle. The first request after reset release is asserted on the second clock edge.
  - REQ: hold o_mem_valid=1 and a stable address until i_mem_ready=1 in the same cycle (handshake). Then drop o_mem_valid and go to WAIT.
  - WAIT: on i_mem_res_valid, write the word into the queue, add 4 to the fetch address, and go to IDLE.
  - DISCARD: entered on a redirect while a response is outstanding. The next i_mem_res_valid is dropped, then go to IDLE.
- At most one request is outstanding at a time.
- Free-space calculation: QUEUE_BYTES - count. A request is issued only if 4 bytes fit.
- Write rules:
  - Bytes are written low to high.
  - For the first word after reset or redirect, the low skip-count bytes are dropped (count += 4 - skip). Skip then clears to 0.
- Read rules:
  - o_window and o_window_bytes = min(count,4) are combinational from the queue head.
  - A response byte is visible in the window the cycle after i_mem_res_valid.
- Consume:
  - head += i_consume; o_window_pc += i_consume.
  - If i_consume > o_window_bytes, consume is clamped to o_window_bytes and o_underflow pulses for one cycle.
- Same cycle as a response: count_next = count - consume + written bytes.
- Head and tail pointers wrap modulo QUEUE_BYTES. Full (count==QUEUE_BYTES) and empty (count==0) are distinguished by the count register.
- Redirect:
  - Empties the queue; o_window_pc = i_redirect_pc; fetch address = i_redirect_pc with [1:0]=0; skip = i_redirect_pc[1:0].
  - From REQ: request withdrawn and state goes to IDLE, unless the handshake completes in that same cycle, in which case state goes to DISCARD.
  - From WAIT: state goes to DISCARD.
  - A response arriving in the redirect cycle is dropped.
- Priority order: reset > redirect > response/consume. i_consume is ignored in a redirect cycle.

Test Plan:
- Memory word 0 = 0x44332211, word 4 = 0x88776655, i_consume=0 → reads to 0x0 then 0x4. After the first response: o_window=0x44332211, bytes=4, pc=0.
- Same memory, i_consume=3 once the window is full → o_window_pc=3, o_window=0x77665544 after the second word lands.
- Hold i_consume=0 → fetches stop after 4 words (count=16). o_mem_valid stays 0 until a consume of ≥1 followed by enough consumes to free 4 bytes.
- Redirect to 0x0000_0006 while in WAIT → stale response dropped. The next request is to 0x4, and the window shows bytes 0x77,0x88 with bytes=2 and pc=6 until word 8 arrives.
- With o_window_bytes=2, drive i_consume=4 → o_underflow pulses for one cycle, the queue empties, and o_window_pc advances by 2.
- Assert reset low for one cycle while o_mem_valid=1 → o_mem_valid=0 on the next cycle, queue empty, o_mem_address=0, fetch restarts at 0.
